prime_search: RTL and testbench

Sequencer directly upstream of `divrem`: on each `go` it finds the next prime above the one it currently holds. It does this by trial division, issuing one `divrem` operation per candidate divisor and consuming the quotient and remainder. It is the top-level compute stage of the prime generator; the host sees only `go`, `ready`, `error` and `prime`.

---
 rtl/primogen_pkg.sv | 30 +++
 rtl/divrem.sv | 93 +++++++++
 rtl/prime_search.sv | 142 ++++++++++++++
 tb/tb_prime_search.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/primogen_pkg.sv
// Shared constants, state encoding and small helpers for the prime generator.
package primogen_pkg;

  localparam int unsigned DATA_W = 16;

  // First trial divisor; never 0, so divrem never sees a zero denominator.
  localparam logic [DATA_W-1:0] FIRST_DIV = 16'd2;

  // prime_search FSM encoding (6 states, 3 bits).
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] StIdle    = 3'd0;
  localparam logic [ST_W-1:0] StInc     = 3'd1;
  localparam logic [ST_W-1:0] StDivGo   = 3'd2;
  localparam logic [ST_W-1:0] StDivHold = 3'd3;
  localparam logic [ST_W-1:0] StDivWait = 3'd4;
  localparam logic [ST_W-1:0] StEval    = 3'd5;

  // Quotient/remainder pair captured from divrem.
  typedef struct packed {
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
  } div_res_t;

  // A divisor d splits c properly only if it leaves no remainder and the
  // quotient is at least 2 (q==1 means d==c, i.e. no proper factor).
  function automatic logic is_composite(input div_res_t res);
    return (res.rem == '0) && (res.quot >= 16'd2);
  endfunction

endpackage

// File: rtl/divrem.sv
// Iterative restoring divider: one quotient bit per cycle, DATA_W cycles per op.
// rst is active-high synchronous. Divide-by-zero raises error without starting.
module divrem
  import primogen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] num,
  input  logic [DATA_W-1:0] den,
  output logic              ready,
  output logic              error,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CntInit = CNT_W'(DATA_W);

  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] den_q, den_d;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              fits;

  // Next-state: accept a new operation when idle, else run one restoring step.
  always_comb begin
    busy_d  = busy_q;
    error_d = error_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    den_d   = den_q;

    // Partial remainder with the next dividend bit shifted in.
    shifted = {rem_q, quot_q[DATA_W-1]};
    diff    = shifted - {1'b0, den_q};
    fits    = shifted >= {1'b0, den_q};

    if (!busy_q) begin
      if (go) begin
        if (den == '0) begin
          error_d = 1'b1;
        end else begin
          error_d = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CntInit;
          rem_d   = '0;
          quot_d  = num;
          den_d   = den;
        end
      end
    end else begin
      // shifted < 2*den, so the restored remainder always fits DATA_W bits.
      rem_d  = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quot_d = {quot_q[DATA_W-2:0], fits};
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == 1) begin
        busy_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      den_q   <= FIRST_DIV;
    end else begin
      busy_q  <= busy_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      den_q   <= den_d;
    end
  end

  assign ready = !busy_q;
  assign error = error_q;
  assign quot  = quot_q;
  assign rem   = rem_q;

endmodule

// File: rtl/prime_search.sv
// Trial-division sequencer: on each accepted go, finds the next prime above
// the one currently held, issuing one divrem operation per candidate divisor.
module prime_search
  import primogen_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_PRIME = 16'd2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              ready,
  output logic              error,
  output logic [DATA_W-1:0] prime
);

  logic [ST_W-1:0]   state_q, state_d;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  div_res_t          res_q, res_d;
  logic [DATA_W-1:0] prime_q, prime_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic              div_go;
  logic              div_ready;
  logic              div_error;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] div_rem;

  divrem u_divrem (
    .clk   (clk),
    .rst   (!rst),
    .go    (div_go),
    .num   (cand_q),
    .den   (dvsr_q),
    .ready (div_ready),
    .error (div_error),
    .quot  (div_quot),
    .rem   (div_rem)
  );

  // Search FSM: increment candidate, try divisors 2.. until a factor or q<d.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dvsr_d  = dvsr_q;
    res_d   = res_q;
    prime_d = prime_q;
    ready_d = ready_q;
    error_d = error_q;
    div_go  = 1'b0;

    case (state_q)
      StIdle: begin
        if (go && !error_q) begin
          cand_d  = prime_q;
          ready_d = 1'b0;
          state_d = StInc;
        end
      end

      StInc: begin
        // Width check before incrementing keeps cand from wrapping.
        if (cand_q == '1) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          cand_d  = cand_q + 1'b1;
          dvsr_d  = FIRST_DIV;
          state_d = StDivGo;
        end
      end

      StDivGo: begin
        div_go  = 1'b1;
        state_d = StDivHold;
      end

      // divrem may still show ready this cycle; ignore it.
      StDivHold: begin
        state_d = StDivWait;
      end

      StDivWait: begin
        if (div_error) begin
          error_d = 1'b1;
          ready_d = 1'b1;
          state_d = StIdle;
        end else if (div_ready) begin
          res_d.quot = div_quot;
          res_d.rem  = div_rem;
          state_d    = StEval;
        end
      end

      StEval: begin
        if (is_composite(res_q)) begin
          state_d = StInc;
        end else if (res_q.quot < dvsr_q) begin
          // q < d implies c < d*d: every smaller divisor has been ruled out.
          prime_d = cand_q;
          ready_d = 1'b1;
          state_d = StIdle;
        end else begin
          dvsr_d  = dvsr_q + 1'b1;
          state_d = StDivGo;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; active-low synchronous reset discards any in-flight search.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cand_q  <= INIT_PRIME;
      dvsr_q  <= FIRST_DIV;
      res_q   <= '0;
      prime_q <= INIT_PRIME;
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      dvsr_q  <= dvsr_d;
      res_q   <= res_d;
      prime_q <= prime_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign ready = ready_q;
  assign error = error_q;
  assign prime = prime_q;

endmodule

// File: tb/tb_prime_search.sv
// Scoreboard bench for prime_search: three instances with different INIT_PRIME.
module tb_prime_search;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst_v;
  logic [2:0]       go_v;
  logic [2:0]       ready_v;
  logic [2:0]       error_v;
  logic [2:0][15:0] prime_v;

  prime_search u_a (
    .clk   (clk),
    .rst   (rst_v[0]),
    .go    (go_v[0]),
    .ready (ready_v[0]),
    .error (error_v[0]),
    .prime (prime_v[0])
  );

  prime_search #(.INIT_PRIME(16'd89)) u_b (
    .clk   (clk),
    .rst   (rst_v[1]),
    .go    (go_v[1]),
    .ready (ready_v[1]),
    .error (error_v[1]),
    .prime (prime_v[1])
  );

  prime_search #(.INIT_PRIME(16'd65519)) u_c (
    .clk   (clk),
    .rst   (rst_v[2]),
    .go    (go_v[2]),
    .ready (ready_v[2]),
    .error (error_v[2]),
    .prime (prime_v[2])
  );

  typedef struct {
    int          dut;
    logic [15:0] prime;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   done_cnt = 0;
  int   gap_viol = 0;
  logic [2:0] ready_prev = 3'b111;
  logic       div_go_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rising edge of ready is a completed search; compare it.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (ready_v[i] === 1'b1 && ready_prev[i] === 1'b0) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_result: dut%0d got prime=%0d error=%0d, expected none",
                   i, prime_v[i], error_v[i]);
        end else begin
          e = sb.pop_front();
          check("result_dut", i, e.dut);
          check("result_prime", {16'd0, prime_v[i]}, {16'd0, e.prime});
          check("result_error", {31'd0, error_v[i]}, {31'd0, e.err});
        end
        done_cnt++;
      end
    end
    ready_prev <= ready_v;
  end

  // divrem.go must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (u_a.div_go && div_go_prev) gap_viol++;
    div_go_prev <= u_a.div_go;
  end

  function automatic bit is_prime(input int n);
    for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int next_prime(input int p);
    int c = p + 1;
    while (!is_prime(c)) c++;
    return c;
  endfunction

  task automatic pulse(input int i);
    @(negedge clk);
    go_v[i] = 1'b1;
    @(negedge clk);
    go_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 20000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt < target) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: timeout, got %0d results, expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic step(input int i, input int p, input bit err);
    int tgt;
    sb.push_back('{i, 16'(p), err});
    tgt = done_cnt + 1;
    pulse(i);
    wait_done(tgt, "step_wait");
  endtask

  task automatic reset_dut(input int i);
    @(negedge clk);
    rst_v[i] = 1'b0;
    @(negedge clk);
    rst_v[i] = 1'b1;
  endtask

  int seq1[9] = '{3, 5, 7, 11, 13, 17, 19, 23, 29};
  int tgt;
  int p;

  initial begin
    rst_v = 3'b000;
    go_v  = 3'b000;
    repeat (3) @(negedge clk);
    rst_v = 3'b111;
    @(negedge clk);

    // Reset state of all instances.
    check("reset_ready_a", {31'd0, ready_v[0]}, 1);
    check("reset_error_a", {31'd0, error_v[0]}, 0);
    check("reset_prime_a", {16'd0, prime_v[0]}, 2);
    check("reset_prime_b", {16'd0, prime_v[1]}, 89);
    check("reset_prime_c", {16'd0, prime_v[2]}, 65519);

    // First primes after 2.
    foreach (seq1[k]) step(0, seq1[k], 1'b0);

    // 89 -> 97 skips composites 90..96.
    step(1, 97, 1'b0);

    // Overflow boundary.
    step(2, 65521, 1'b0);
    step(2, 65521, 1'b1);
    tgt = done_cnt;
    pulse(2);
    repeat (50) @(negedge clk);
    check("ovf_no_new_result", done_cnt, tgt);
    check("ovf_ready", {31'd0, ready_v[2]}, 1);
    check("ovf_error", {31'd0, error_v[2]}, 1);
    check("ovf_prime", {16'd0, prime_v[2]}, 65521);

    // go while busy is ignored.
    reset_dut(0);
    check("rereset_prime_a", {16'd0, prime_v[0]}, 2);
    step(0, 3, 1'b0);
    step(0, 5, 1'b0);
    step(0, 7, 1'b0);
    sb.push_back('{0, 16'd11, 1'b0});
    tgt = done_cnt + 1;
    pulse(0);
    repeat (2) @(negedge clk);
    check("busy_ready_low", {31'd0, ready_v[0]}, 0);
    check("busy_prime_held", {16'd0, prime_v[0]}, 7);
    pulse(0);
    wait_done(tgt, "dbl_go_wait");
    repeat (300) @(negedge clk);
    check("dbl_go_single_result", done_cnt, tgt);
    check("dbl_go_prime", {16'd0, prime_v[0]}, 11);

    // Walk up to 113, then reset mid-search.
    p = 11;
    while (p < 113) begin
      p = next_prime(p);
      step(0, p, 1'b0);
    end
    sb.push_back('{0, 16'd2, 1'b0});
    tgt = done_cnt + 1;
    pulse(0);
    repeat (30) @(negedge clk);
    check("mid_search_busy", {31'd0, ready_v[0]}, 0);
    rst_v[0] = 1'b0;
    @(negedge clk);
    rst_v[0] = 1'b1;
    wait_done(tgt, "mid_reset_wait");
    step(0, 3, 1'b0);

    // go held high: back-to-back searches.
    reset_dut(0);
    gap_viol = 0;
    sb.push_back('{0, 16'd3, 1'b0});
    sb.push_back('{0, 16'd5, 1'b0});
    sb.push_back('{0, 16'd7, 1'b0});
    tgt = done_cnt + 3;
    @(negedge clk);
    go_v[0] = 1'b1;
    wait_done(tgt, "held_go_wait");
    go_v[0] = 1'b0;
    repeat (200) @(negedge clk);
    check("held_go_count", done_cnt, tgt);
    check("held_go_prime", {16'd0, prime_v[0]}, 7);
    check("held_go_ready", {31'd0, ready_v[0]}, 1);
    check("divrem_go_gap", gap_viol, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
